// File: rtl/memory_access_unit.sv
// Memory stage: issues byte/half/word data-memory requests over valid/ready,
// aligns and extends load data, and stalls upstream while an access is in flight.
module memory_access_unit #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 20
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    store,
  input  logic [2:0]              funct3,
  input  logic [DATA_WIDTH-1:0]   ALU_result,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [4:0]              regDest_in,
  input  logic                    regEn_in,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDRESS_BITS-1:0] mem_req_addr,
  output logic                    mem_req_we,
  output logic [3:0]              mem_req_byte_en,
  output logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    stall,
  output logic                    access_fault,
  output logic [DATA_WIDTH-1:0]   regRead_m,
  output logic [4:0]              regDest_m,
  output logic                    regEn_m,
  input  logic                    report
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0]   sdata_q, sdata_d;
  logic [4:0]              dest_q, dest_d;
  logic                    en_q, en_d;
  logic                    is_load_q, is_load_d;
  logic [DATA_WIDTH-1:0]   read_q, read_d;
  logic [4:0]              rdest_q, rdest_d;
  logic                    ren_q, ren_d;
  logic                    fault_q, fault_d;

  logic                    mem_access;
  logic                    illegal;
  logic                    in_req;
  logic [3:0]              byte_en;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   lane;
  logic [DATA_WIDTH-1:0]   load_value;

  // Status reporting is a simulation aid only; the datapath ignores it.
  logic                    unused_report;
  logic [31:0]             unused_core;
  assign unused_report = report;
  assign unused_core   = 32'(CORE);

  assign mem_access = load | store;
  assign illegal    = (load && store)
                    || (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
                    || (store && funct3[2])
                    || ((funct3[1:0] == 2'b01) && ALU_result[0])
                    || ((funct3[1:0] == 2'b10) && (ALU_result[1:0] != 2'b00));

  always_comb begin
    byte_en = 4'b1111;
    wdata   = sdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_q[1:0];
        wdata   = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{sdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = mem_resp_data >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_value = lane;
    case (funct3_q)
      3'b000:  load_value = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_value = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_value = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_value = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    funct3_d  = funct3_q;
    sdata_d   = sdata_q;
    dest_d    = dest_q;
    en_d      = en_q;
    is_load_d = is_load_q;
    read_d    = read_q;
    rdest_d   = rdest_q;
    ren_d     = ren_q;
    fault_d   = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!mem_access) begin
          read_d  = ALU_result;
          rdest_d = regDest_in;
          ren_d   = regEn_in;
        end else if (illegal) begin
          ren_d   = 1'b0;
          fault_d = 1'b1;
        end else begin
          stall     = 1'b1;
          addr_d    = ALU_result[ADDRESS_BITS-1:0];
          funct3_d  = funct3;
          sdata_d   = store_data;
          dest_d    = regDest_in;
          en_d      = regEn_in;
          is_load_d = load;
          ren_d     = 1'b0;
          state_d   = StReq;
        end
      end
      StReq: begin
        stall = 1'b1;
        if (mem_req_ready) begin
          state_d = is_load_q ? StWait : StDone;
        end
      end
      StWait: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          read_d  = load_value;
          rdest_d = dest_q;
          ren_d   = en_q;
          state_d = StDone;
        end
      end
      StDone: begin
        // Upstream still presents the finished access this cycle; leave a bubble.
        ren_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      funct3_q  <= '0;
      sdata_q   <= '0;
      dest_q    <= '0;
      en_q      <= 1'b0;
      is_load_q <= 1'b0;
      read_q    <= '0;
      rdest_q   <= '0;
      ren_q     <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      funct3_q  <= funct3_d;
      sdata_q   <= sdata_d;
      dest_q    <= dest_d;
      en_q      <= en_d;
      is_load_q <= is_load_d;
      read_q    <= read_d;
      rdest_q   <= rdest_d;
      ren_q     <= ren_d;
      fault_q   <= fault_d;
    end
  end

  assign in_req          = (state_q == StReq);
  assign mem_req_valid   = in_req;
  assign mem_req_addr    = in_req ? {addr_q[ADDRESS_BITS-1:2], 2'b00} : '0;
  assign mem_req_we      = in_req & ~is_load_q;
  assign mem_req_byte_en = in_req ? byte_en : 4'b0000;
  assign mem_req_data    = in_req ? wdata : '0;
  assign access_fault    = fault_q;
  assign regRead_m       = read_q;
  assign regDest_m       = rdest_q;
  assign regEn_m         = ren_q;

endmodule
